// File: rtl/alarm_zone_controller.sv
// Intrusion alarm sequencer: exit delay, armed watch over maskable zones, entry delay, timed siren.
// Define ALARM_ZONE_TAMPER_EN to add the tamper input and the sticky tamper_flag output.
module alarm_zone_controller #(
    parameter int NUM_ZONES   = 4,
    parameter int EXIT_DELAY  = 16,
    parameter int ENTRY_DELAY = 16,
    parameter int SIREN_TIME  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_req,
    input  logic                 disarm_req,
    input  logic [NUM_ZONES-1:0] zone_in,
    input  logic [NUM_ZONES-1:0] zone_mask,
`ifdef ALARM_ZONE_TAMPER_EN
    input  logic                 tamper,
    output logic                 tamper_flag,
`endif
    output logic [2:0]           state,
    output logic                 alarm,
    output logic [2:0]           zone_id,
    output logic                 zone_valid,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    localparam logic [15:0] EXIT_LOAD  = 16'(EXIT_DELAY);
    localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_DELAY);
    localparam logic [15:0] SIREN_LOAD = 16'(SIREN_TIME);

    state_t                state_q;
    logic [15:0]           cnt;
    logic [NUM_ZONES-1:0]  zone_active;

    // Highest index is scanned first so the lowest active index wins.
    function automatic logic [2:0] lowest_zone(input logic [NUM_ZONES-1:0] act);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (act[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign zone_active = zone_in & ~zone_mask;
    assign state       = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_DISARMED;
            cnt         <= 16'd0;
            alarm       <= 1'b0;
            zone_id     <= 3'd0;
            zone_valid  <= 1'b0;
            busy        <= 1'b0;
`ifdef ALARM_ZONE_TAMPER_EN
            tamper_flag <= 1'b0;
`endif
        end else if (disarm_req) begin
            // Disarm beats arm and tamper; zone_id is kept as a record of the last trigger.
            state_q     <= S_DISARMED;
            cnt         <= 16'd0;
            alarm       <= 1'b0;
            zone_valid  <= 1'b0;
            busy        <= 1'b0;
`ifdef ALARM_ZONE_TAMPER_EN
            tamper_flag <= 1'b0;
`endif
        end
`ifdef ALARM_ZONE_TAMPER_EN
        else if (tamper) begin
            state_q     <= S_ALARM;
            cnt         <= SIREN_LOAD;
            alarm       <= 1'b1;
            busy        <= 1'b1;
            tamper_flag <= 1'b1;
        end
`endif
        else begin
            case (state_q)
                S_DISARMED: begin
                    if (arm_req) begin
                        state_q <= S_EXIT_DLY;
                        cnt     <= EXIT_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_EXIT_DLY: begin
                    if (cnt == 16'd1) begin
                        state_q <= S_ARMED;
                        cnt     <= 16'd0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_ARMED: begin
                    if (|zone_active) begin
                        state_q    <= S_ENTRY_DLY;
                        cnt        <= ENTRY_LOAD;
                        zone_id    <= lowest_zone(zone_active);
                        zone_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ENTRY_DLY: begin
                    if (cnt == 16'd1) begin
                        state_q <= S_ALARM;
                        cnt     <= SIREN_LOAD;
                        alarm   <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_ALARM: begin
                    if (cnt == 16'd1) begin
                        state_q <= S_ARMED;
                        cnt     <= 16'd0;
                        alarm   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_DISARMED;
                    cnt     <= 16'd0;
                    alarm   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Bench for alarm_zone_controller: directed scenarios plus random traffic against a cycle-count model.
module tb_alarm_zone_controller;

    localparam int NZ    = 4;
    localparam int EXIT  = 4;
    localparam int ENTRY = 4;
    localparam int SIREN = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm_req;
    logic          disarm_req;
    logic [NZ-1:0] zone_in;
    logic [NZ-1:0] zone_mask;
    logic [2:0]    state;
    logic          alarm;
    logic [2:0]    zone_id;
    logic          zone_valid;
    logic          busy;
    logic          tamper;
`ifdef ALARM_ZONE_TAMPER_EN
    logic          tamper_flag;
`endif

    alarm_zone_controller #(
        .NUM_ZONES  (NZ),
        .EXIT_DELAY (EXIT),
        .ENTRY_DELAY(ENTRY),
        .SIREN_TIME (SIREN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm_req    (arm_req),
        .disarm_req (disarm_req),
        .zone_in    (zone_in),
        .zone_mask  (zone_mask),
`ifdef ALARM_ZONE_TAMPER_EN
        .tamper     (tamper),
        .tamper_flag(tamper_flag),
`endif
        .state      (state),
        .alarm      (alarm),
        .zone_id    (zone_id),
        .zone_valid (zone_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode plus number of whole cycles already spent in it.
    int       m_mode;
    int       m_spent;
    bit [2:0] m_zid;
    bit       m_zvalid;
    bit       m_tflag;

    function automatic void model_reset();
        m_mode = 0; m_spent = 0; m_zid = 0; m_zvalid = 0; m_tflag = 0;
    endfunction

    function automatic void model_step(input bit a, input bit d, input bit t, input bit [NZ-1:0] act);
        bit found;
        if (d) begin
            m_mode = 0; m_spent = 0; m_zvalid = 0; m_tflag = 0;
        end else if (t) begin
            m_mode = 4; m_spent = 0; m_tflag = 1;
        end else begin
            case (m_mode)
                0: if (a) begin m_mode = 1; m_spent = 0; end
                1: begin m_spent++; if (m_spent == EXIT)  begin m_mode = 2; m_spent = 0; end end
                2: if (act != 0) begin
                       found = 0;
                       for (int i = 0; i < NZ; i++)
                           if (act[i] && !found) begin m_zid = 3'(i); found = 1; end
                       m_zvalid = 1; m_mode = 3; m_spent = 0;
                   end
                3: begin m_spent++; if (m_spent == ENTRY) begin m_mode = 4; m_spent = 0; end end
                4: begin m_spent++; if (m_spent == SIREN) begin m_mode = 2; m_spent = 0; end end
                default: m_mode = 0;
            endcase
        end
    endfunction

    task automatic compare_all();
        check("state", 32'(state), 32'(m_mode));
        check("alarm", 32'(alarm), 32'(m_mode == 4));
        check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 3 || m_mode == 4));
        check("zone_id", 32'(zone_id), 32'(m_zid));
        check("zone_valid", 32'(zone_valid), 32'(m_zvalid));
`ifdef ALARM_ZONE_TAMPER_EN
        check("tamper_flag", 32'(tamper_flag), 32'(m_tflag));
`endif
    endtask

    // One clock: drive inputs, let the edge pass, update the model, compare 1 time unit later.
    task automatic cycle(input bit a, input bit d, input bit t, input bit [NZ-1:0] zi, input bit [NZ-1:0] zm);
        arm_req = a; disarm_req = d; tamper = t; zone_in = zi; zone_mask = zm;
        @(posedge clk);
`ifdef ALARM_ZONE_TAMPER_EN
        model_step(a, d, t, zi & ~zm);
`else
        model_step(a, d, 1'b0, zi & ~zm);
`endif
        #1;
        compare_all();
        arm_req = 0; disarm_req = 0; tamper = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_zone_valid", 32'(zone_valid), 32'd0);
        check("rst_zone_id", 32'(zone_id), 32'd0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    int alarm_seen;

    initial begin
        rst = 1'b1; arm_req = 0; disarm_req = 0; tamper = 0; zone_in = '0; zone_mask = '0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Arm: four cycles of exit delay, then armed with busy dropping on the same edge.
        cycle(1, 0, 0, '0, '0);
        check("exit_state", 32'(state), 32'd1);
        idle(3);
        check("exit_last", 32'(state), 32'd1);
        check("exit_busy", 32'(busy), 32'd1);
        idle(1);
        check("armed", 32'(state), 32'd2);
        check("armed_busy", 32'(busy), 32'd0);

        // Trigger on zones 1 and 2: lowest index latched, entry delay, then an 8-cycle siren.
        cycle(0, 0, 0, 4'b0110, '0);
        check("trig_id", 32'(zone_id), 32'd1);
        check("trig_valid", 32'(zone_valid), 32'd1);
        idle(3);
        check("entry_last", 32'(state), 32'd3);
        idle(1);
        check("alarm_on", 32'(alarm), 32'd1);
        check("alarm_state", 32'(state), 32'd4);
        alarm_seen = 1;
        for (int i = 0; i < 7; i++) begin
            idle(1);
            alarm_seen += int'(alarm);
        end
        check("siren_len", 32'(alarm_seen), 32'(SIREN));
        idle(1);
        check("siren_end", 32'(state), 32'd2);
        check("held_valid", 32'(zone_valid), 32'd1);

        // Disarm in the second entry-delay cycle: siren never sounds.
        alarm_seen = 0;
        cycle(0, 0, 0, 4'b0001, '0);
        alarm_seen += int'(alarm);
        idle(1);
        alarm_seen += int'(alarm);
        cycle(0, 1, 0, '0, '0);
        alarm_seen += int'(alarm);
        check("dis_state", 32'(state), 32'd0);
        check("dis_valid", 32'(zone_valid), 32'd0);
        check("dis_id_kept", 32'(zone_id), 32'd0);
        check("dis_no_alarm", 32'(alarm_seen), 32'd0);

        // Masked zone is ignored; simultaneous arm+disarm stays disarmed.
        cycle(1, 0, 0, '0, '0);
        idle(4);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'b0001, 4'b0001);
        check("mask_state", 32'(state), 32'd2);
        cycle(0, 1, 0, '0, '0);
        cycle(1, 1, 0, '0, '0);
        check("armdis_state", 32'(state), 32'd0);

        // Asynchronous reset in the middle of the siren.
        cycle(1, 0, 0, '0, '0);
        idle(4);
        cycle(0, 0, 0, 4'b1000, '0);
        check("z3_id", 32'(zone_id), 32'd3);
        idle(6);
        check("pre_rst_alarm", 32'(alarm), 32'd1);
        async_reset();
        idle(2);
        check("post_rst_wait", 32'(state), 32'd0);

`ifdef ALARM_ZONE_TAMPER_EN
        cycle(0, 0, 1, '0, '0);
        check("tamper_state", 32'(state), 32'd4);
        check("tamper_alarm", 32'(alarm), 32'd1);
        check("tamper_flag", 32'(tamper_flag), 32'd1);
        cycle(0, 1, 0, '0, '0);
        check("tamper_clear", 32'(tamper_flag), 32'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit a, d, t;
            bit [NZ-1:0] zi, zm;
            a  = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 59) == 0);
`ifdef ALARM_ZONE_TAMPER_EN
            t  = ($urandom_range(0, 199) == 0);
`else
            t  = 1'b0;
`endif
            zi = ($urandom_range(0, 3) == 0) ? NZ'($urandom) : '0;
            zm = ($urandom_range(0, 1) == 0) ? NZ'($urandom) : '0;
            if ($urandom_range(0, 399) == 0) async_reset();
            cycle(a, d, t, zi, zm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_zone_controller.md
ALARM_ZONE_CONTROLLER -- requirements
Module: alarm_zone_controller

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4, number of sensor zones (2..8).
REQ-002 SHALL have parameter EXIT_DELAY, default 16, cycles spent in EXIT_DLY (1..65535).
REQ-003 SHALL have parameter ENTRY_DELAY, default 16, cycles spent in ENTRY_DLY (1..65535).
REQ-004 SHALL have parameter SIREN_TIME, default 64, cycles of siren per ALARM episode (1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port arm_req  input  1  single-cycle arm request.
REQ-008 SHALL have port disarm_req  input  1  single-cycle disarm request.
REQ-009 SHALL have port zone_in  input  NUM_ZONES  level sensor inputs, bit i = zone i.
REQ-010 SHALL have port zone_mask  input  NUM_ZONES  1 = zone bypassed (ignored).
REQ-011 SHALL have port state  output  3  current FSM state encoding.
REQ-012 SHALL have port alarm  output  1  siren drive.
REQ-013 SHALL have port zone_id  output  3  index of zone that caused the current/last trigger.
REQ-014 SHALL have port zone_valid  output  1  zone_id holds a latched trigger.
REQ-015 SHALL have port busy  output  1  high while a delay or siren counter is running.

Function
REQ-016 SHALL implement states DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4; codes 5-7 go to DISARMED next cycle.
REQ-017 SHALL treat a zone as active when zone_in[i]=1 and zone_mask[i]=0; masking is evaluated every cycle.
REQ-018 SHALL move DISARMED -> EXIT_DLY on arm_req, loading a 16-bit down-counter; arm_req in any other state is ignored.
REQ-019 SHALL stay in EXIT_DLY exactly EXIT_DELAY cycles, then enter ARMED; zone activity during EXIT_DLY is ignored.
REQ-020 SHALL move ARMED -> ENTRY_DLY on the first cycle any zone is active, latching the lowest-index active zone into zone_id and setting zone_valid.
REQ-021 SHALL stay in ENTRY_DLY exactly ENTRY_DELAY cycles, then enter ALARM; further zone activity does not change zone_id.
REQ-022 SHALL assert alarm in every cycle state==ALARM and only then; both are registered outputs changing on the same edge.
REQ-023 SHALL stay in ALARM exactly SIREN_TIME cycles, then return to ARMED with zone_id/zone_valid held; a zone still active re-triggers ENTRY_DLY on the following cycle.
REQ-024 SHALL move any state to DISARMED on disarm_req on the next edge, clearing counter, alarm and zone_valid; zone_id retains its value.
REQ-025 SHALL give disarm_req priority when arm_req and disarm_req are high in the same cycle.
REQ-026 SHALL assert busy in EXIT_DLY, ENTRY_DLY and ALARM, low otherwise.
REQ-027 SHALL saturate nothing: counter loads parameter value and decrements to 1 before state exit; no wrap-around is reachable.

Reset
REQ-028 SHALL on rst=1 asynchronously force state=DISARMED, alarm=0, zone_id=0, zone_valid=0, busy=0, counter=0.
REQ-029 SHALL, with rst asserted mid-delay or mid-siren, abandon the operation; after release the block waits in DISARMED for arm_req.

Configuration
REQ-030 SHALL, with macro ALARM_ZONE_TAMPER_EN defined, add input port tamper (1 bit) and output tamper_flag (1 bit, reset 0).
REQ-031 SHALL, with ALARM_ZONE_TAMPER_EN defined, on tamper=1 in any state enter ALARM next edge bypassing delays, set tamper_flag, leave zone_id/zone_valid unchanged; disarm_req clears tamper_flag.
REQ-032 SHALL, with ALARM_ZONE_TAMPER_EN undefined, have neither port and behave exactly per REQ-016..REQ-027.

Verification
REQ-033 SHALL test: EXIT_DELAY=4, pulse arm_req -> state=1 for 4 cycles, then state=2, busy falls with the transition.
REQ-034 SHALL test: ARMED, zone_in=4'b0110 -> zone_id=1, zone_valid=1, ENTRY_DELAY=4 cycles later state=4, alarm=1 for SIREN_TIME=8 cycles, then state=2.
REQ-035 SHALL test: ENTRY_DLY, disarm_req at cycle 2 -> state=0 next edge, alarm never asserted, zone_valid=0.
REQ-036 SHALL test: zone_mask=4'b0001, zone_in=4'b0001 in ARMED -> state stays 2; same cycle arm_req+disarm_req in DISARMED -> state stays 0.
REQ-037 SHALL test: rst pulse during ALARM -> alarm=0 and state=0 immediately, before next clk edge.
REQ-038 SHALL test (ALARM_ZONE_TAMPER_EN): tamper=1 in DISARMED -> state=4, alarm=1, tamper_flag=1 next edge; disarm_req -> tamper_flag=0.
